// File: rtl/keylock_pkg.sv
// Shared types and helpers for the parametrised keypad lock.
package keylock_pkg;

    // Lock controller states.
    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        PROG    = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    // Upper bounds for the generic helpers below; callers cast to their own widths.
    localparam int unsigned MAX_DIGIT_W = 16;
    localparam int unsigned MAX_CODE_W  = 256;

    // All-ones digit of the given width: the CLEAR key.
    function automatic logic [MAX_DIGIT_W-1:0] clear_key(input int unsigned digit_w);
        logic [MAX_DIGIT_W-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < MAX_DIGIT_W; i++) begin
            k[i] = (i < digit_w) ? 1'b1 : 1'b0;
        end
        return k;
    endfunction

    // Digit idx of a packed code; digit 0 sits in the most significant position.
    function automatic logic [MAX_DIGIT_W-1:0] code_digit(
        input logic [MAX_CODE_W-1:0] code,
        input int unsigned           idx,
        input int unsigned           code_len,
        input int unsigned           digit_w
    );
        logic [MAX_CODE_W-1:0] sh;
        sh = code >> ((code_len - 32'd1 - idx) * digit_w);
        return sh[MAX_DIGIT_W-1:0] & clear_key(digit_w);
    endfunction

endpackage

// File: rtl/keylock_timer.sv
// Loadable down-counter that parks at zero; load wins over decrement.
module keylock_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: reload, decrement towards zero, or hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/keylock_multi.sv
// Parametrised keypad lock: code entry, run-time reprogramming,
// failed-attempt lockout and optional auto-relock on inactivity.
module keylock_multi
    import keylock_pkg::*;
#(
    parameter int unsigned                   DIGIT_W        = 4,
    parameter int unsigned                   CODE_LEN       = 6,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE   = 24'h336256,
    parameter int unsigned                   MAX_FAILS      = 3,
    parameter int unsigned                   LOCKOUT_CYCLES = 1024,
    parameter int unsigned                   AUTO_RELOCK    = 0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [DIGIT_W-1:0]               key,
    input  logic                             key_valid,
    input  logic                             lock_req,
    input  logic                             prog_en,
    output logic                             locked,
    output logic                             lockout,
    output logic                             prog_mode,
    output logic                             fail_pulse,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

    localparam int unsigned CW = CODE_LEN * DIGIT_W;
    localparam int unsigned IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned RW = (AUTO_RELOCK > 1) ? $clog2(AUTO_RELOCK + 1) : 1;

    localparam logic [DIGIT_W-1:0] CLEAR_VAL   = DIGIT_W'(clear_key(DIGIT_W));
    localparam logic [IW-1:0]      LAST_IDX    = IW'(CODE_LEN - 1);
    localparam logic [FW-1:0]      FAIL_MAX    = FW'(MAX_FAILS);
    // Timers are loaded with N-1 so the exit edge lands exactly N cycles after entry.
    localparam logic [LW-1:0]      LOCK_LOAD   = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [RW-1:0]      RELOCK_LOAD = RW'((AUTO_RELOCK > 0) ? AUTO_RELOCK - 1 : 0);
    localparam logic               RELOCK_EN   = (AUTO_RELOCK > 0) ? 1'b1 : 1'b0;

    state_e              state_q,      state_d;
    logic [IW-1:0]       idx_q,        idx_d;
    logic                flag_q,       flag_d;
    logic [CW-1:0]       code_q,       code_d;
    logic [CW-1:0]       shadow_q,     shadow_d;
    logic                locked_q,     locked_d;
    logic                lockout_q,    lockout_d;
    logic                prog_mode_q,  prog_mode_d;
    logic                fail_pulse_q, fail_pulse_d;
    logic [FW-1:0]       fail_cnt_q,   fail_cnt_d;

    logic [DIGIT_W-1:0]  cur_digit_s;
    logic                is_clear_s;
    logic                mism_s;
    logic [FW-1:0]       fail_inc_s;
    int unsigned         wr_shift_s;
    logic [CW-1:0]       wr_mask_s;
    logic [CW-1:0]       wr_data_s;
    logic                lock_load_s;
    logic                lock_zero_s;
    logic                relock_load_s;
    logic                relock_zero_s;

    assign cur_digit_s = DIGIT_W'(code_digit(MAX_CODE_W'(code_q), 32'(idx_q), CODE_LEN, DIGIT_W));
    assign is_clear_s  = (key == CLEAR_VAL);
    assign mism_s      = flag_q | (key != cur_digit_s);
    assign fail_inc_s  = (fail_cnt_q == FAIL_MAX) ? FAIL_MAX : fail_cnt_q + FW'(1);
    assign wr_shift_s  = (CODE_LEN - 32'd1 - 32'(idx_q)) * DIGIT_W;
    assign wr_mask_s   = CW'({DIGIT_W{1'b1}}) << wr_shift_s;
    assign wr_data_s   = CW'(key) << wr_shift_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        flag_d       = flag_q;
        code_d       = code_q;
        shadow_d     = shadow_q;
        fail_pulse_d = 1'b0;
        fail_cnt_d   = fail_cnt_q;
        lock_load_s  = 1'b0;
        case (state_q)
            ENTRY: begin
                if (!key_valid) begin
                    state_d = ENTRY;
                end else if (is_clear_s) begin
                    idx_d  = '0;
                    flag_d = 1'b0;
                end else if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    flag_d = 1'b0;
                    if (!mism_s) begin
                        state_d    = OPEN;
                        fail_cnt_d = '0;
                    end else begin
                        fail_pulse_d = 1'b1;
                        fail_cnt_d   = fail_inc_s;
                        if (fail_inc_s == FAIL_MAX) begin
                            state_d     = LOCKOUT;
                            lock_load_s = 1'b1;
                        end else begin
                            state_d = ENTRY;
                        end
                    end
                end else begin
                    idx_d  = idx_q + IW'(1);
                    flag_d = mism_s;
                end
            end
            OPEN: begin
                if (lock_req) begin
                    state_d = ENTRY;
                end else if (prog_en) begin
                    state_d  = PROG;
                    idx_d    = '0;
                    shadow_d = code_q;
                end else if (key_valid) begin
                    state_d = OPEN;
                end else if (RELOCK_EN && relock_zero_s) begin
                    state_d = ENTRY;
                end else begin
                    state_d = OPEN;
                end
            end
            PROG: begin
                if (lock_req) begin
                    state_d = ENTRY;
                    idx_d   = '0;
                end else if (key_valid && is_clear_s) begin
                    idx_d = '0;
                end else if (key_valid) begin
                    shadow_d = (shadow_q & ~wr_mask_s) | (wr_data_s & wr_mask_s);
                    if (idx_q == LAST_IDX) begin
                        code_d  = shadow_d;
                        state_d = OPEN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = PROG;
                end
            end
            LOCKOUT: begin
                if (lock_zero_s) begin
                    state_d    = ENTRY;
                    fail_cnt_d = '0;
                end else begin
                    state_d = LOCKOUT;
                end
            end
            default: begin
                state_d = ENTRY;
                idx_d   = '0;
                flag_d  = 1'b0;
            end
        endcase
        relock_load_s = (state_d == OPEN) && ((state_q != OPEN) || key_valid);
        locked_d      = (state_d == ENTRY) || (state_d == LOCKOUT);
        lockout_d     = (state_d == LOCKOUT);
        prog_mode_d   = (state_d == PROG);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ENTRY;
            idx_q        <= '0;
            flag_q       <= 1'b0;
            code_q       <= DEFAULT_CODE;
            shadow_q     <= DEFAULT_CODE;
            locked_q     <= 1'b1;
            lockout_q    <= 1'b0;
            prog_mode_q  <= 1'b0;
            fail_pulse_q <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            flag_q       <= flag_d;
            code_q       <= code_d;
            shadow_q     <= shadow_d;
            locked_q     <= locked_d;
            lockout_q    <= lockout_d;
            prog_mode_q  <= prog_mode_d;
            fail_pulse_q <= fail_pulse_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    keylock_timer #(.WIDTH(LW)) u_lock_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (lock_load_s),
        .load_val (LOCK_LOAD),
        .en       (state_q == LOCKOUT),
        .zero     (lock_zero_s)
    );

    keylock_timer #(.WIDTH(RW)) u_relock_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (relock_load_s),
        .load_val (RELOCK_LOAD),
        .en       (state_q == OPEN),
        .zero     (relock_zero_s)
    );

    assign locked     = locked_q;
    assign lockout    = lockout_q;
    assign prog_mode  = prog_mode_q;
    assign fail_pulse = fail_pulse_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_keylock_multi.sv
// Directed bench for keylock_multi (LOCKOUT_CYCLES=16, AUTO_RELOCK=8).
module tb_keylock_multi;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] key = 4'd0;
    logic       key_valid = 1'b0;
    logic       lock_req = 1'b0;
    logic       prog_en = 1'b0;
    logic       locked;
    logic       lockout;
    logic       prog_mode;
    logic       fail_pulse;
    logic [1:0] fail_cnt;

    int nvec = 0;
    int nerr = 0;

    keylock_multi #(
        .DIGIT_W        (4),
        .CODE_LEN       (6),
        .DEFAULT_CODE   (24'h336256),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (16),
        .AUTO_RELOCK    (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key        (key),
        .key_valid  (key_valid),
        .lock_req   (lock_req),
        .prog_en    (prog_en),
        .locked     (locked),
        .lockout    (lockout),
        .prog_mode  (prog_mode),
        .fail_pulse (fail_pulse),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    // One strobe; returns on the negedge after the sampling posedge.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key = 4'd0;
    endtask

    // Press the first n digits of a 6-digit code, MS digit first.
    task automatic press_code(input logic [23:0] c, input int n);
        logic [23:0] v;
        v = c;
        for (int i = 0; i < n; i++) begin
            press(v[23:20]);
            v = v << 4;
        end
    endtask

    task automatic do_lock();
        @(negedge clk);
        lock_req = 1'b1;
        @(negedge clk);
        lock_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL reset_locked: got %0b want 1", locked); end
        nvec++; if (lockout !== 1'b0) begin nerr++; $display("FAIL reset_lockout: got %0b want 0", lockout); end
        nvec++; if (prog_mode !== 1'b0) begin nerr++; $display("FAIL reset_prog: got %0b want 0", prog_mode); end
        nvec++; if (fail_pulse !== 1'b0) begin nerr++; $display("FAIL reset_pulse: got %0b want 0", fail_pulse); end
        nvec++; if (fail_cnt !== 2'd0) begin nerr++; $display("FAIL reset_cnt: got %0d want 0", fail_cnt); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unlock();
        press_code(24'h336256, 5);
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL unlock_early: got %0b want 1", locked); end
        press(4'h6);
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL unlock_locked: got %0b want 0", locked); end
        nvec++; if (fail_pulse !== 1'b0) begin nerr++; $display("FAIL unlock_pulse: got %0b want 0", fail_pulse); end
        nvec++; if (fail_cnt !== 2'd0) begin nerr++; $display("FAIL unlock_cnt: got %0d want 0", fail_cnt); end
        do_lock();
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL relock_req: got %0b want 1", locked); end
    endtask

    task automatic test_wrong_code();
        press_code(24'h336257, 6);
        nvec++; if (fail_pulse !== 1'b1) begin nerr++; $display("FAIL wrong_pulse: got %0b want 1", fail_pulse); end
        nvec++; if (fail_cnt !== 2'd1) begin nerr++; $display("FAIL wrong_cnt: got %0d want 1", fail_cnt); end
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL wrong_locked: got %0b want 1", locked); end
        @(negedge clk);
        nvec++; if (fail_pulse !== 1'b0) begin nerr++; $display("FAIL wrong_pulse_width: got %0b want 0", fail_pulse); end
        press_code(24'h336256, 6);
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL retry_locked: got %0b want 0", locked); end
        nvec++; if (fail_cnt !== 2'd0) begin nerr++; $display("FAIL retry_cnt: got %0d want 0", fail_cnt); end
        do_lock();
    endtask

    task automatic test_lockout();
        press_code(24'h336257, 6);
        press_code(24'h111111, 6);
        nvec++; if (fail_cnt !== 2'd2) begin nerr++; $display("FAIL lo_cnt2: got %0d want 2", fail_cnt); end
        nvec++; if (lockout !== 1'b0) begin nerr++; $display("FAIL lo_early: got %0b want 0", lockout); end
        press_code(24'h652533, 6);
        nvec++; if (lockout !== 1'b1) begin nerr++; $display("FAIL lo_enter: got %0b want 1", lockout); end
        nvec++; if (fail_cnt !== 2'd3) begin nerr++; $display("FAIL lo_cnt3: got %0d want 3", fail_cnt); end
        nvec++; if (fail_pulse !== 1'b1) begin nerr++; $display("FAIL lo_pulse: got %0b want 1", fail_pulse); end
        // 12 cycles of correct-code strobes while locked out
        press_code(24'h336256, 6);
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL lo_ignore_locked: got %0b want 1", locked); end
        nvec++; if (lockout !== 1'b1) begin nerr++; $display("FAIL lo_hold12: got %0b want 1", lockout); end
        repeat (3) @(negedge clk);
        nvec++; if (lockout !== 1'b1) begin nerr++; $display("FAIL lo_hold15: got %0b want 1", lockout); end
        @(negedge clk);
        nvec++; if (lockout !== 1'b0) begin nerr++; $display("FAIL lo_exit16: got %0b want 0", lockout); end
        nvec++; if (fail_cnt !== 2'd0) begin nerr++; $display("FAIL lo_exit_cnt: got %0d want 0", fail_cnt); end
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL lo_exit_locked: got %0b want 1", locked); end
        press_code(24'h336256, 6);
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL lo_after_unlock: got %0b want 0", locked); end
        do_lock();
    endtask

    task automatic test_program();
        press_code(24'h336256, 6);
        @(negedge clk);
        prog_en = 1'b1;
        @(negedge clk);
        prog_en = 1'b0;
        nvec++; if (prog_mode !== 1'b1) begin nerr++; $display("FAIL prog_enter: got %0b want 1", prog_mode); end
        press_code(24'h123456, 5);
        nvec++; if (prog_mode !== 1'b1) begin nerr++; $display("FAIL prog_hold: got %0b want 1", prog_mode); end
        press(4'h6);
        nvec++; if (prog_mode !== 1'b0) begin nerr++; $display("FAIL prog_done: got %0b want 0", prog_mode); end
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL prog_open: got %0b want 0", locked); end
        do_lock();
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL prog_relock: got %0b want 1", locked); end
        press_code(24'h336256, 6);
        nvec++; if (fail_pulse !== 1'b1) begin nerr++; $display("FAIL prog_old_rej: got %0b want 1", fail_pulse); end
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL prog_old_locked: got %0b want 1", locked); end
        press_code(24'h123456, 6);
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL prog_new_unlock: got %0b want 0", locked); end
        nvec++; if (fail_cnt !== 2'd0) begin nerr++; $display("FAIL prog_new_cnt: got %0d want 0", fail_cnt); end
        do_lock();
    endtask

    task automatic test_auto_relock();
        press_code(24'h123456, 6);
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL ar_unlock: got %0b want 0", locked); end
        repeat (7) @(negedge clk);
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL ar_idle7: got %0b want 0", locked); end
        @(negedge clk);
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL ar_idle8: got %0b want 1", locked); end
    endtask

    task automatic test_clear_and_reset();
        logic [3:0] seq [9];
        seq = '{4'h1, 4'h2, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        for (int i = 0; i < 9; i++) begin
            press(seq[i]);
            nvec++; if (fail_pulse !== 1'b0) begin nerr++; $display("FAIL clr_pulse[%0d]: got %0b want 0", i, fail_pulse); end
        end
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL clr_unlock: got %0b want 0", locked); end
        @(negedge clk);
        prog_en = 1'b1;
        @(negedge clk);
        prog_en = 1'b0;
        press(4'h9);
        press(4'h8);
        nvec++; if (prog_mode !== 1'b1) begin nerr++; $display("FAIL rst_inprog: got %0b want 1", prog_mode); end
        #2 reset_n = 1'b0;
        #1;
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL rst_async_locked: got %0b want 1", locked); end
        nvec++; if (prog_mode !== 1'b0) begin nerr++; $display("FAIL rst_async_prog: got %0b want 0", prog_mode); end
        @(negedge clk);
        reset_n = 1'b1;
        press_code(24'h123456, 6);
        nvec++; if (fail_pulse !== 1'b1) begin nerr++; $display("FAIL rst_prog_code_rej: got %0b want 1", fail_pulse); end
        press_code(24'h336256, 6);
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL rst_default_unlock: got %0b want 0", locked); end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_wrong_code();
        test_lockout();
        test_program();
        test_auto_relock();
        test_clear_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
